pixel_transmitter: RTL and testbench

PIXEL_TRANSMITTER -- requirements
Module: pixel_transmitter

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing_counter.sv | 69 ++++++
 rtl/pixel_transmitter.sv | 118 +++++++++++
 tb/tb_pixel_transmitter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing defaults, total derivations and small decode helpers
// for the pixel transmitter and its timing counter.
package vga_pkg;

  localparam int DEF_WIDTH       = 640;
  localparam int DEF_HEIGHT      = 480;
  localparam int DEF_WIDTH_BITS  = 10;
  localparam int DEF_HEIGHT_BITS = 9;
  localparam int DEF_PIXEL_BITS  = 12;
  localparam int DEF_H_FRONT     = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BACK      = 48;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BACK      = 33;

  function automatic int frame_total(input int visible, input int front,
                                     input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL = frame_total(DEF_WIDTH, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int V_TOTAL = frame_total(DEF_HEIGHT, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  // Both counters share one width, sized for the longer of the two totals.
  localparam int CNT_BITS = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

  typedef logic [DEF_PIXEL_BITS-1:0] pixel_t;
  typedef logic [CNT_BITS-1:0]       count_t;

  function automatic logic in_window(input count_t pos, input count_t lo, input count_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster scan counters with combinational active-area and sync decode
// (stage 0 of the transmitter pipeline).
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  output logic [WIDTH_BITS-1:0]  o_x,
  output logic [HEIGHT_BITS-1:0] o_y,
  output logic                   o_active,
  output logic                   o_h_sync_n,
  output logic                   o_v_sync_n
);

  localparam int H_TOT = frame_total(WIDTH, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOT = frame_total(HEIGHT, V_FRONT, V_SYNC, V_BACK);

  localparam count_t CNT_ZERO = count_t'(0);
  localparam count_t CNT_ONE  = count_t'(1);
  localparam count_t H_LAST   = count_t'(H_TOT - 1);
  localparam count_t V_LAST   = count_t'(V_TOT - 1);
  localparam count_t H_VIS    = count_t'(WIDTH);
  localparam count_t V_VIS    = count_t'(HEIGHT);
  localparam count_t HS_LO    = count_t'(WIDTH + H_FRONT);
  localparam count_t HS_HI    = count_t'(WIDTH + H_FRONT + H_SYNC);
  localparam count_t VS_LO    = count_t'(HEIGHT + V_FRONT);
  localparam count_t VS_HI    = count_t'(HEIGHT + V_FRONT + V_SYNC);

  count_t r_h;
  count_t r_v;

  // Raster scan: h advances every pixel, v advances only when h wraps.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_h <= CNT_ZERO;
      r_v <= CNT_ZERO;
    end else if (r_h == H_LAST) begin
      r_h <= CNT_ZERO;
      if (r_v == V_LAST) begin
        r_v <= CNT_ZERO;
      end else begin
        r_v <= r_v + CNT_ONE;
      end
    end else begin
      r_h <= r_h + CNT_ONE;
    end
  end

  // Decode straight from the counters; hsync deliberately ignores v.
  always_comb begin
    o_active   = (r_h < H_VIS) && (r_v < V_VIS);
    o_h_sync_n = ~in_window(r_h, HS_LO, HS_HI);
    o_v_sync_n = ~in_window(r_v, VS_LO, VS_HI);
    o_x        = r_h[WIDTH_BITS-1:0];
    o_y        = r_v[HEIGHT_BITS-1:0];
  end

endmodule

// File: rtl/pixel_transmitter.sv
// VGA-style pixel transmitter: issues frame-buffer reads from the raster
// counters and aligns coordinates, syncs and returned pixel one cycle later.
module pixel_transmitter
  import vga_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
  parameter int PIXEL_BITS  = DEF_PIXEL_BITS,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK
) (
  input  logic                              clock_in,
  input  logic                              reset_n_in,
  output logic [WIDTH_BITS+HEIGHT_BITS-1:0] mem_addr_out,
  output logic                              mem_read_out,
  input  logic [PIXEL_BITS-1:0]             mem_data_in,
  output logic [WIDTH_BITS-1:0]             pixel_x_out,
  output logic [HEIGHT_BITS-1:0]            pixel_y_out,
  output logic [PIXEL_BITS-1:0]             pixel_out,
  output logic                              video_on_out,
  output logic                              h_sync_out,
  output logic                              v_sync_out,
  output logic                              frame_start_out
);

  localparam logic [WIDTH_BITS-1:0]             X_ZERO    = {WIDTH_BITS{1'b0}};
  localparam logic [HEIGHT_BITS-1:0]            Y_ZERO    = {HEIGHT_BITS{1'b0}};
  localparam logic [WIDTH_BITS+HEIGHT_BITS-1:0] ADDR_ZERO = {(WIDTH_BITS+HEIGHT_BITS){1'b0}};
  localparam logic [PIXEL_BITS-1:0]             PIX_ZERO  = {PIXEL_BITS{1'b0}};

  logic [WIDTH_BITS-1:0]  w_x;
  logic [HEIGHT_BITS-1:0] w_y;
  logic                   w_active;
  logic                   w_h_sync_n;
  logic                   w_v_sync_n;
  logic                   w_first;

  logic [WIDTH_BITS-1:0]  r_pixel_x;
  logic [HEIGHT_BITS-1:0] r_pixel_y;
  logic                   r_video_on;
  logic                   r_h_sync;
  logic                   r_v_sync;
  logic                   r_frame_start;

  vga_timing_counter #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .WIDTH_BITS  (WIDTH_BITS),
    .HEIGHT_BITS (HEIGHT_BITS),
    .H_FRONT     (H_FRONT),
    .H_SYNC      (H_SYNC),
    .H_BACK      (H_BACK),
    .V_FRONT     (V_FRONT),
    .V_SYNC      (V_SYNC),
    .V_BACK      (V_BACK)
  ) u_timing (
    .i_clock    (clock_in),
    .i_reset_n  (reset_n_in),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_active   (w_active),
    .o_h_sync_n (w_h_sync_n),
    .o_v_sync_n (w_v_sync_n)
  );

  // Stage 0: read request for the pixel under the counters; address parks at 0 in blanking.
  always_comb begin
    mem_read_out = w_active;
    w_first      = w_active && (w_x == X_ZERO) && (w_y == Y_ZERO);
    if (w_active) begin
      mem_addr_out = {w_y, w_x};
    end else begin
      mem_addr_out = ADDR_ZERO;
    end
  end

  // Stage 1: coordinates and flags land in the same cycle as the read data.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_pixel_x     <= X_ZERO;
      r_pixel_y     <= Y_ZERO;
      r_video_on    <= 1'b0;
      r_h_sync      <= 1'b1;
      r_v_sync      <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel_x     <= w_x;
      r_pixel_y     <= w_y;
      r_video_on    <= w_active;
      r_h_sync      <= w_h_sync_n;
      r_v_sync      <= w_v_sync_n;
      r_frame_start <= w_first;
    end
  end

  // Memory data is only meaningful while the registered visible flag is set.
  always_comb begin
    if (r_video_on) begin
      pixel_out = mem_data_in;
    end else begin
      pixel_out = PIX_ZERO;
    end
  end

  assign pixel_x_out     = r_pixel_x;
  assign pixel_y_out     = r_pixel_y;
  assign video_on_out    = r_video_on;
  assign h_sync_out      = r_h_sync;
  assign v_sync_out      = r_v_sync;
  assign frame_start_out = r_frame_start;

endmodule

// File: tb/tb_pixel_transmitter.sv
// Self-checking bench for pixel_transmitter, run with a short frame (20 visible
// lines, 30 total) so whole-frame properties fit in a short simulation.
module tb_pixel_transmitter;

  localparam int W        = 640;
  localparam int HGT      = 20;
  localparam int HF       = 16;
  localparam int HSL      = 96;
  localparam int HB       = 48;
  localparam int VF       = 4;
  localparam int VSL      = 2;
  localparam int VB       = 4;
  localparam int HT       = 800;
  localparam int VT       = 30;
  localparam int FRAME    = HT * VT;
  localparam int HS_START = 656;
  localparam int HS_END   = 752;
  localparam int VS_START = 24;
  localparam int VS_END   = 26;
  localparam int NROW     = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] mem_addr;
  logic        mem_read;
  logic [11:0] mem_data = 12'd0;
  logic [9:0]  px;
  logic [8:0]  py;
  logic [11:0] pix;
  logic        von, hs, vs, fs;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        von;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] pix;
  } out_t;

  typedef struct {
    int          h;
    int          v;
    logic        von;
    logic        hs;
    logic        vs;
    logic [11:0] pix;
  } row_t;

  row_t tbl [NROW];
  out_t sbq [$];

  int   total = 0;
  int   bad = 0;
  int   mh, mv, cyc;
  logic sb_on;
  logic have_fs, prev_hs, prev_vs;
  int   fs_cyc, rd_cnt, von_cnt, vs_low, hs_vis_bad, hs_fall_cyc;

  always #5 clk = ~clk;

  pixel_transmitter #(
    .WIDTH(W), .HEIGHT(HGT), .WIDTH_BITS(10), .HEIGHT_BITS(9), .PIXEL_BITS(12),
    .H_FRONT(HF), .H_SYNC(HSL), .H_BACK(HB), .V_FRONT(VF), .V_SYNC(VSL), .V_BACK(VB)
  ) dut (
    .clock_in        (clk),
    .reset_n_in      (rst_n),
    .mem_addr_out    (mem_addr),
    .mem_read_out    (mem_read),
    .mem_data_in     (mem_data),
    .pixel_x_out     (px),
    .pixel_y_out     (py),
    .pixel_out       (pix),
    .video_on_out    (von),
    .h_sync_out      (hs),
    .v_sync_out      (vs),
    .frame_start_out (fs)
  );

  // Frame-buffer model: returns address[11:0] one cycle after a strobe, junk otherwise.
  always @(posedge clk) mem_data <= mem_read ? mem_addr[11:0] : 12'hBAD;

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic out_t expect_at(input int h, input int v);
    out_t e;
    logic act;
    act   = (h < W) && (v < HGT);
    e.x   = 10'(h);
    e.y   = 9'(v);
    e.von = act;
    e.hs  = !((h >= HS_START) && (h < HS_END));
    e.vs  = !((v >= VS_START) && (v < VS_END));
    e.fs  = (h == 0) && (v == 0);
    e.pix = act ? 12'((v << 10) | h) : 12'd0;
    return e;
  endfunction

  task automatic observe();
    out_t a, e;
    logic act;
    a = {px, py, von, hs, vs, fs, pix};
    if (sb_on) chk("sb_depth", 64'(sbq.size()), 64'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (sb_on) chk("stage1", 64'(a), 64'(e));
    end
    act = (mh < W) && (mv < HGT);
    if (sb_on) begin
      chk("stage0_read", 64'(mem_read), 64'(act));
      chk("stage0_addr", 64'(mem_addr), act ? 64'((mv << 10) | mh) : 64'd0);
    end
    sbq.push_back(expect_at(mh, mv));
    if (fs) begin
      if (have_fs) begin
        chk("frame_period", 64'(cyc - fs_cyc), 64'(FRAME));
        chk("read_count", 64'(rd_cnt), 64'(W * HGT));
        chk("video_count", 64'(von_cnt), 64'(W * HGT));
        chk("vsync_low", 64'(vs_low), 64'(VSL * HT));
        chk("hs_in_visible", 64'(hs_vis_bad), 64'd0);
      end
      have_fs = 1'b1; fs_cyc = cyc;
      rd_cnt = 0; von_cnt = 0; vs_low = 0; hs_vis_bad = 0;
    end
    if (mem_read) rd_cnt++;
    if (von) von_cnt++;
    if (!vs) vs_low++;
    if (von && !hs) hs_vis_bad++;
    if (prev_hs && !hs) begin
      chk("hs_fall_x", 64'(px), 64'(HS_START));
      hs_fall_cyc = cyc;
    end
    if (!prev_hs && hs) begin
      chk("hs_rise_x", 64'(px), 64'(HS_END));
      chk("hs_width", 64'(cyc - hs_fall_cyc), 64'(HSL));
    end
    if (prev_vs && !vs) begin
      chk("vs_fall_y", 64'(py), 64'(VS_START));
      chk("vs_fall_x", 64'(px), 64'd0);
    end
    prev_hs = hs;
    prev_vs = vs;
  endtask

  task automatic tick();
    @(posedge clk);
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    cyc++;
    sb_on = (cyc < 2 * HT + 10) || ((mv >= 22) && (mv <= 27));
    @(negedge clk);
    observe();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"}, 64'(px), 64'd0);
    chk({tag, "_y"}, 64'(py), 64'd0);
    chk({tag, "_von"}, 64'(von), 64'd0);
    chk({tag, "_hs"}, 64'(hs), 64'd1);
    chk({tag, "_vs"}, 64'(vs), 64'd1);
    chk({tag, "_fs"}, 64'(fs), 64'd0);
    chk({tag, "_pix"}, 64'(pix), 64'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("c0_addr", 64'(mem_addr), 64'd0);
    chk("c0_read", 64'(mem_read), 64'd1);
    mh = 0; mv = 0; cyc = 0; sb_on = 1'b1;
    sbq.delete();
    sbq.push_back(expect_at(0, 0));
    have_fs = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    tick();
    chk("c1_fs", 64'(fs), 64'd1);
    chk("c1_x", 64'(px), 64'd0);
    chk("c1_y", 64'(py), 64'd0);
    chk("c1_von", 64'(von), 64'd1);
  endtask

  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    repeat (2) @(negedge clk);
    check_reset_vals({tag, "_hold"});
  endtask

  initial begin
    int tgt;
    tbl[0]  = '{h: 10,  v: 0,  von: 1'b1, hs: 1'b1, vs: 1'b1, pix: 12'h00A};
    tbl[1]  = '{h: 639, v: 0,  von: 1'b1, hs: 1'b1, vs: 1'b1, pix: 12'h27F};
    tbl[2]  = '{h: 640, v: 0,  von: 1'b0, hs: 1'b1, vs: 1'b1, pix: 12'h000};
    tbl[3]  = '{h: 655, v: 0,  von: 1'b0, hs: 1'b1, vs: 1'b1, pix: 12'h000};
    tbl[4]  = '{h: 656, v: 0,  von: 1'b0, hs: 1'b0, vs: 1'b1, pix: 12'h000};
    tbl[5]  = '{h: 751, v: 0,  von: 1'b0, hs: 1'b0, vs: 1'b1, pix: 12'h000};
    tbl[6]  = '{h: 752, v: 0,  von: 1'b0, hs: 1'b1, vs: 1'b1, pix: 12'h000};
    tbl[7]  = '{h: 799, v: 0,  von: 1'b0, hs: 1'b1, vs: 1'b1, pix: 12'h000};
    tbl[8]  = '{h: 0,   v: 1,  von: 1'b1, hs: 1'b1, vs: 1'b1, pix: 12'h400};
    tbl[9]  = '{h: 5,   v: 3,  von: 1'b1, hs: 1'b1, vs: 1'b1, pix: 12'hC05};
    tbl[10] = '{h: 10,  v: 19, von: 1'b1, hs: 1'b1, vs: 1'b1, pix: 12'hC0A};
    tbl[11] = '{h: 639, v: 19, von: 1'b1, hs: 1'b1, vs: 1'b1, pix: 12'hE7F};
    tbl[12] = '{h: 0,   v: 20, von: 1'b0, hs: 1'b1, vs: 1'b1, pix: 12'h000};
    tbl[13] = '{h: 100, v: 23, von: 1'b0, hs: 1'b1, vs: 1'b1, pix: 12'h000};
    tbl[14] = '{h: 100, v: 24, von: 1'b0, hs: 1'b1, vs: 1'b0, pix: 12'h000};
    tbl[15] = '{h: 799, v: 25, von: 1'b0, hs: 1'b1, vs: 1'b0, pix: 12'h000};
    tbl[16] = '{h: 0,   v: 26, von: 1'b0, hs: 1'b1, vs: 1'b1, pix: 12'h000};
    tbl[17] = '{h: 700, v: 29, von: 1'b0, hs: 1'b0, vs: 1'b1, pix: 12'h000};

    cyc = 0; mh = 0; mv = 0; sb_on = 1'b0;
    have_fs = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    fs_cyc = 0; rd_cnt = 0; von_cnt = 0; vs_low = 0; hs_vis_bad = 0; hs_fall_cyc = 0;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    release_reset();

    for (int i = 0; i < NROW; i++) begin
      tgt = tbl[i].v * HT + tbl[i].h + 1;
      while (cyc < tgt) tick();
      chk($sformatf("row%0d_x", i), 64'(px), 64'(tbl[i].h));
      chk($sformatf("row%0d_y", i), 64'(py), 64'(tbl[i].v));
      chk($sformatf("row%0d_von", i), 64'(von), 64'(tbl[i].von));
      chk($sformatf("row%0d_hs", i), 64'(hs), 64'(tbl[i].hs));
      chk($sformatf("row%0d_vs", i), 64'(vs), 64'(tbl[i].vs));
      chk($sformatf("row%0d_pix", i), 64'(pix), 64'(tbl[i].pix));
    end

    // Second frame start happens on the way to v=15 h=400 of that frame.
    while (cyc < FRAME + 15 * HT + 400) tick();
    chk("pre_mid_fs_seen", 64'(fs_cyc), 64'(FRAME + 1));
    assert_reset("mid");
    release_reset();

    // Abort an hsync pulse in flight: output h=699 is inside the pulse.
    while (cyc < 700) tick();
    chk("pre_abort_hs", 64'(hs), 64'd0);
    assert_reset("sync_abort");
    release_reset();
    repeat (5) tick();
    chk("post_abort_x", 64'(px), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
